// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU and load
// writebacks, with per-register pending counters for hazard detection.
module rf_wb_arbiter #(
    parameter int DW   = 24,
    parameter int AW   = 6,
    parameter int NREG = 8,
    parameter int CW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          hz1,
    output logic          hz2,
    output logic          rf_we,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_wdata,
    output logic          bad_rd
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [AW-1:0] NREG_A = AW'(NREG);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    // rr_q: 0 favours ALU, 1 favours MEM when both are valid
    logic          rr_q, rr_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_rd_q, rf_rd_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          bad_rd_q, bad_rd_d;
    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];

    logic          alu_fire, mem_fire, wr_fire, iss_fire;
    logic [AW-1:0] wr_rd;
    logic [DW-1:0] wr_data;
    logic          wr_live, wr_oob, iss_live, iss_oob;
    logic [IW-1:0] wr_idx, iss_idx, rs1_idx, rs2_idx;
    logic          underflow;

    // Handshakes: ready depends only on the valids, pointer and reset
    always_comb begin
        alu_ready = rst_n & (~mem_valid | ~rr_q);
        mem_ready = rst_n & (~alu_valid | rr_q);
        alu_fire  = alu_valid & alu_ready;
        mem_fire  = mem_valid & mem_ready;
        wr_fire   = alu_fire | mem_fire;
        wr_rd     = alu_fire ? alu_rd : mem_rd;
        wr_data   = alu_fire ? alu_data : mem_data;
        wr_live   = (wr_rd != '0) && (wr_rd < NREG_A);
        wr_oob    = wr_rd >= NREG_A;
        wr_idx    = wr_rd[IW-1:0];
        iss_idx   = iss_rd[IW-1:0];
        iss_live  = (iss_rd != '0) && (iss_rd < NREG_A);
        iss_oob   = iss_rd >= NREG_A;
        iss_ready = rst_n & ~(iss_live && (cnt_q[iss_idx] == CMAX));
        iss_fire  = iss_valid & iss_ready;
    end

    // Hazard lookup against the current pending counters
    always_comb begin
        rs1_idx = rs1[IW-1:0];
        rs2_idx = rs2[IW-1:0];
        hz1 = (rs1 != '0) && (rs1 < NREG_A) && (cnt_q[rs1_idx] != '0);
        hz2 = (rs2 != '0) && (rs2 < NREG_A) && (cnt_q[rs2_idx] != '0);
    end

    // Next-state: pointer, write port, pending counters, sticky error
    always_comb begin
        rr_d       = rr_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        underflow  = 1'b0;
        cnt_d      = cnt_q;
        if (alu_fire) rr_d = 1'b1;
        if (mem_fire) rr_d = 1'b0;
        if (wr_fire && wr_live) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = wr_rd;
            rf_wdata_d = wr_data;
        end
        cnt_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            if (iss_fire && iss_live && iss_idx == IW'(i)) begin
                if (!(wr_fire && wr_live && wr_idx == IW'(i)))
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (wr_fire && wr_live && wr_idx == IW'(i)) begin
                if (cnt_q[i] == '0) underflow = 1'b1;
                else cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        bad_rd_d = bad_rd_q | (wr_fire & wr_oob) | (iss_fire & iss_oob) | underflow;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            bad_rd_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            rr_q       <= rr_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            bad_rd_q   <= bad_rd_d;
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign bad_rd   = bad_rd_q;

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Param DW, 24, data width of register-file write data.
REQ-002 Param AW, 6, register index width.
REQ-003 Param NREG, 8, implemented registers (indices 0..NREG-1); R0 hardwired zero.
REQ-004 Param CW, 2, width of per-register pending counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 alu_valid / alu_ready  in/out  1/1  ALU writeback handshake.
REQ-008 alu_rd / alu_data  in  AW/DW  ALU destination and result.
REQ-009 mem_valid / mem_ready  in/out  1/1  load writeback handshake.
REQ-010 mem_rd / mem_data  in  AW/DW  load destination and data.
REQ-011 iss_valid / iss_ready  in/out  1/1  issue handshake; marks iss_rd pending.
REQ-012 iss_rd  in  AW  destination of the instruction being issued.
REQ-013 rs1 / rs2  in  AW/AW  source indices to hazard-check.
REQ-014 hz1 / hz2  out  1/1  source has pending write.
REQ-015 rf_we / rf_rd / rf_wdata  out  1/AW/DW  registered register-file write port.
REQ-016 bad_rd  out  1  sticky flag: out-of-range index seen.

Function
REQ-017 Transfer on a source when valid&&ready in the same cycle; ready SHALL be combinational from the valids and the RR pointer only.
REQ-018 At most one source granted per cycle; lone valid source is granted.
REQ-019 Both valid: grant the source named by the RR pointer (0=ALU, 1=MEM).
REQ-020 After any grant, pointer SHALL point to the non-granted source; no grant leaves it unchanged.
REQ-021 Granted transfer with rd in 1..NREG-1 SHALL drive rf_we=1, rf_rd=rd, rf_wdata=data on the next cycle (latency 1); otherwise rf_we=0 next cycle.
REQ-022 Granted transfer with rd=0 SHALL be accepted and discarded (rf_we=0).
REQ-023 Granted transfer with rd>=NREG SHALL be accepted, discarded, and set bad_rd.
REQ-024 Each register 1..NREG-1 has a CW-bit pending counter; R0 never pending.
REQ-025 Issue accepted (iss_valid&&iss_ready) with iss_rd in 1..NREG-1 increments cnt[iss_rd].
REQ-026 iss_ready=0 when iss_rd in range and cnt[iss_rd]=2^CW-1 (saturated); else 1.
REQ-027 Issue with iss_rd=0 accepted, no effect; iss_rd>=NREG accepted, sets bad_rd.
REQ-028 Granted write with rd in 1..NREG-1 decrements cnt[rd] in the grant cycle; counter at 0 SHALL stay 0 and set bad_rd.
REQ-029 Simultaneous issue increment and write decrement on the same register SHALL leave the count unchanged.
REQ-030 hz1 = (rs1 in 1..NREG-1) && cnt[rs1]!=0; hz2 likewise; combinational from current counters.
REQ-031 Both sources same rd, both valid: serialized by RR; register file sees both writes in grant order, one cycle apart.
REQ-032 bad_rd clears only on reset.

Reset
REQ-033 rst_n=0 SHALL immediately force rf_we=0, rf_rd=0, rf_wdata=0, all counters 0, RR pointer=ALU, bad_rd=0.
REQ-034 Transfers presented while rst_n=0 are ignored; ready outputs are 0 during reset.
REQ-035 Reset asserted mid-transfer discards the registered write; first post-reset cycle SHALL show rf_we=0.

Verification
REQ-036 Reset, then alu_valid with rd=3, data=0x00ABCD -> alu_ready=1 same cycle; next cycle rf_we=1, rf_rd=3, rf_wdata=0x00ABCD.
REQ-037 Both valid every cycle, ALU rd=1, MEM rd=2, from reset -> grants ALU,MEM,ALU,MEM; rf_rd sequence 1,2,1,2.
REQ-038 Issue rd=5 three times -> cnt=3, iss_ready=0 on fourth; rs1=5 -> hz1=1; three MEM writes rd=5 -> hz1=0 after third grant cycle.
REQ-039 Issue rd=4 and ALU write rd=4 same cycle with cnt=1 -> cnt stays 1, hz=1.
REQ-040 MEM write rd=0 -> rf_we=0, bad_rd=0; ALU write rd=9 -> rf_we=0, bad_rd=1, remains 1 until rst_n=0.
REQ-041 Assert rst_n=0 the cycle after a grant -> rf_we=0 immediately, counters 0, pointer ALU.
